// File: rtl/pe_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
// Holds the FSM encoding, saturation limits and the width check.
package pe_pkg;

  typedef enum logic {
    PE_IDLE = 1'b0,
    PE_ACC  = 1'b1
  } pe_state_e;

  localparam int ACC_RATIO = 2;

  function automatic bit acc_width_ok(int w, int aw);
    return aw >= ACC_RATIO * w;
  endfunction

  // Limits are built 64 bits wide; callers keep the low ACC_WIDTH bits.
  function automatic logic [63:0] sat_max(int aw, bit sgn);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < aw - 1 || (i == aw - 1 && !sgn)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] sat_min(int aw, bit sgn);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i == aw - 1 && sgn) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_mac_cell_if.sv
// Operand, forwarding, result and flag signals of one PE.
// Master is the array/testbench side, slave is the cell.
interface pe_mac_cell_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
);
  logic [WIDTH-1:0]     A_IN;
  logic                 A_VALID_IN;
  logic                 A_FIRST_IN;
  logic                 A_LAST_IN;
  logic [WIDTH-1:0]     B_IN;
  logic                 B_VALID_IN;
  logic [WIDTH-1:0]     A_OUT;
  logic                 A_VALID_OUT;
  logic                 A_FIRST_OUT;
  logic                 A_LAST_OUT;
  logic [WIDTH-1:0]     B_OUT;
  logic                 B_VALID_OUT;
  logic [ACC_WIDTH-1:0] RES_DATA;
  logic                 RES_VALID;
  logic                 RES_READY;
  logic                 RES_SAT;
  logic                 DROP_ERR;
  logic                 PROTO_ERR;
  logic                 FLAG_CLR;

  modport master (
    output A_IN, A_VALID_IN, A_FIRST_IN, A_LAST_IN,
    output B_IN, B_VALID_IN, RES_READY, FLAG_CLR,
    input  A_OUT, A_VALID_OUT, A_FIRST_OUT, A_LAST_OUT,
    input  B_OUT, B_VALID_OUT,
    input  RES_DATA, RES_VALID, RES_SAT, DROP_ERR, PROTO_ERR
  );

  modport slave (
    input  A_IN, A_VALID_IN, A_FIRST_IN, A_LAST_IN,
    input  B_IN, B_VALID_IN, RES_READY, FLAG_CLR,
    output A_OUT, A_VALID_OUT, A_FIRST_OUT, A_LAST_OUT,
    output B_OUT, B_VALID_OUT,
    output RES_DATA, RES_VALID, RES_SAT, DROP_ERR, PROTO_ERR
  );

endinterface

// File: rtl/pe_sat_add.sv
// Combinational saturating adder, signed or unsigned.
// sat flags that the true sum fell outside the WIDTH-bit range.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);

  localparam logic [63:0] MAX64 = sat_max(WIDTH, SIGNED);
  localparam logic [63:0] MIN64 = sat_min(WIDTH, SIGNED);
  localparam logic [WIDTH-1:0] MAXV = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MINV = MIN64[WIDTH-1:0];

  logic [WIDTH:0] wide;

  always_comb begin
    wide = {1'b0, a} + {1'b0, b};
    sum  = wide[WIDTH-1:0];
    sat  = 1'b0;
    if (SIGNED) begin
      // Overflow only when both addends share a sign the result lacks.
      if (a[WIDTH-1] == b[WIDTH-1] && wide[WIDTH-1] != a[WIDTH-1]) begin
        sat = 1'b1;
        sum = a[WIDTH-1] ? MINV : MAXV;
      end
    end else if (wide[WIDTH]) begin
      sat = 1'b1;
      sum = MAXV;
    end
  end

endmodule

// File: rtl/pe_mac_cell.sv
// Systolic PE: forwards A east and B south, accumulates one
// framed dot product and offers it on a valid/ready result port.
module pe_mac_cell
  import pe_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter bit SIGNED    = 1'b0
) (
  input logic          CLK,
  input logic          RST,
  pe_mac_cell_if.slave io
);

  if (!acc_width_ok(WIDTH, ACC_WIDTH)) begin : g_bad_width
    $error("pe_mac_cell: ACC_WIDTH must be at least 2*WIDTH");
  end

  pe_state_e state_q, state_d;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] prod_ext, add_sum, mac_sum;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
  logic                 sat_q, sat_d, add_sat, mac_sat;
  logic                 mac, restart, proto_set;
  logic                 capture, accept, drop_set;

  assign mac = io.A_VALID_IN && io.B_VALID_IN;

  always_comb begin
    if (SIGNED) begin
      a_ext = (2*WIDTH)'($signed(io.A_IN));
      b_ext = (2*WIDTH)'($signed(io.B_IN));
    end else begin
      a_ext = (2*WIDTH)'(io.A_IN);
      b_ext = (2*WIDTH)'(io.B_IN);
    end
    // Low 2*WIDTH bits are exact for both signednesses.
    prod = a_ext * b_ext;
    if (SIGNED) prod_ext = ACC_WIDTH'($signed(prod));
    else        prod_ext = ACC_WIDTH'(prod);
  end

  pe_sat_add #(
    .WIDTH  (ACC_WIDTH),
    .SIGNED (SIGNED)
  ) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= PE_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mac) state_d = io.A_LAST_IN ? PE_IDLE : PE_ACC;
  end

  always_comb begin
    restart   = (state_q == PE_IDLE) || io.A_FIRST_IN;
    proto_set = mac && ((state_q == PE_IDLE) ? !io.A_FIRST_IN
                                             : io.A_FIRST_IN);
    mac_sum   = restart ? prod_ext : add_sum;
    mac_sat   = restart ? 1'b0 : (sat_q || add_sat);
    acc_d     = mac ? mac_sum : acc_q;
    sat_d     = mac ? mac_sat : sat_q;
    capture   = mac && io.A_LAST_IN;
    accept    = io.RES_VALID && io.RES_READY;
    drop_set  = capture && io.RES_VALID && !io.RES_READY;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      io.A_OUT       <= '0;
      io.A_VALID_OUT <= 1'b0;
      io.A_FIRST_OUT <= 1'b0;
      io.A_LAST_OUT  <= 1'b0;
      io.B_OUT       <= '0;
      io.B_VALID_OUT <= 1'b0;
    end else begin
      io.A_OUT       <= io.A_IN;
      io.A_VALID_OUT <= io.A_VALID_IN;
      io.A_FIRST_OUT <= io.A_FIRST_IN;
      io.A_LAST_OUT  <= io.A_LAST_IN;
      io.B_OUT       <= io.B_IN;
      io.B_VALID_OUT <= io.B_VALID_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      io.RES_DATA  <= '0;
      io.RES_SAT   <= 1'b0;
      io.RES_VALID <= 1'b0;
    end else if (capture) begin
      io.RES_DATA  <= mac_sum;
      io.RES_SAT   <= mac_sat;
      io.RES_VALID <= 1'b1;
    end else if (accept) begin
      io.RES_VALID <= 1'b0;
    end
  end

  // Set has priority over FLAG_CLR on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      io.DROP_ERR  <= 1'b0;
      io.PROTO_ERR <= 1'b0;
    end else begin
      io.DROP_ERR  <= drop_set || (io.DROP_ERR && !io.FLAG_CLR);
      io.PROTO_ERR <= proto_set || (io.PROTO_ERR && !io.FLAG_CLR);
    end
  end

endmodule
